clock_monitor: RTL and testbench

- Synthesizable checker for the clock generator interface. It observes one generated clock (mon_clk) asynchronously, using a faster reference clock.
- Reports the following:
  - start phase: reference cycles from enable to the first mon_clk edge
  - per-window rising-edge count, which is proportional to frequency
  - frequency-change events
  - gate open/close events
- Sits in the bench/checker layer next to each generated clock and feeds scoreboards and assertions.

---
 rtl/clock_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_clock_monitor.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Clock monitor: watches one generated clock (mon_clk) from the faster reference CLOCK and
// reports start phase, per-window rising-edge count, frequency changes and gate open/close.
// Optional duty measurement (high_count) is built when CLOCK_MONITOR_DUTY_EN is defined.
`timescale 1ns/1ps
module clock_monitor #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned GATE_TIMEOUT  = 64,
  parameter int unsigned TOL           = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             enable,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] first_edge_dly,
  output logic             first_edge_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             freq_change,
  output logic             gate_closed,
  output logic             gate_event,
`ifdef CLOCK_MONITOR_DUTY_EN
  output logic [CNT_W-1:0] high_count,
`endif
  output logic             overflow
);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StGated} state_e;

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] WinLast  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(GATE_TIMEOUT - 1);
  localparam logic [CNT_W:0]   TolW     = (CNT_W + 1)'(TOL);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;
  logic                   mon_sync;
  logic                   mon_rise;
  logic [CNT_W-1:0]       phase_q;
  logic [CNT_W-1:0]       win_cnt_q;
  logic [CNT_W-1:0]       edge_cnt_q;
  logic [CNT_W-1:0]       idle_cnt_q;
  logic [CNT_W-1:0]       prev_q;
  logic                   hist_q;

  logic                   edge_sat;
  logic [CNT_W-1:0]       edge_nxt;
  logic                   win_done;
  logic                   gate_to;
  logic [CNT_W:0]         diff;

  assign mon_sync = sync_q[SYNC_STAGES-1];
  assign mon_rise = mon_sync & ~sync_d_q;

  // Synchronizer chain for the asynchronous monitored clock plus the edge-detect delay flop.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q   <= '0;
      sync_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], mon_clk};
      sync_d_q <= mon_sync;
    end
  end

  // Saturating edge count including this cycle's edge, window/gate terminals, |count - prev|.
  always_comb begin
    edge_sat = mon_rise && (edge_cnt_q == CntMax);
    edge_nxt = (mon_rise && !edge_sat) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    win_done = (win_cnt_q == WinLast);
    gate_to  = !mon_rise && (idle_cnt_q == IdleLast);
    if (edge_nxt >= prev_q) begin
      diff = {1'b0, edge_nxt} - {1'b0, prev_q};
    end else begin
      diff = {1'b0, prev_q} - {1'b0, edge_nxt};
    end
  end

`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] high_nxt;
  logic             high_sat;
  logic             in_measure;

  assign in_measure = enable && (state_q == StMeasure);
  assign high_sat   = mon_sync && (high_cnt_q == CntMax);
  assign high_nxt   = (mon_sync && !high_sat) ? high_cnt_q + 1'b1 : high_cnt_q;

  // High-time counter tracks the window counter; it loads high_count when the window closes.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      high_cnt_q <= '0;
      high_count <= '0;
    end else if (in_measure && !gate_to) begin
      if (win_done) begin
        high_count <= high_nxt;
        high_cnt_q <= '0;
      end else begin
        high_cnt_q <= high_nxt;
      end
    end else begin
      high_cnt_q <= '0;
    end
  end
`else
  logic high_sat;
  assign high_sat = 1'b0;
`endif

  // Monitor FSM: counters, registered results and registered single-cycle pulses.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q          <= StIdle;
      phase_q          <= '0;
      win_cnt_q        <= '0;
      edge_cnt_q       <= '0;
      idle_cnt_q       <= '0;
      prev_q           <= '0;
      hist_q           <= 1'b0;
      first_edge_dly   <= '0;
      first_edge_valid <= 1'b0;
      meas_count       <= '0;
      meas_valid       <= 1'b0;
      freq_change      <= 1'b0;
      gate_closed      <= 1'b0;
      gate_event       <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      first_edge_valid <= 1'b0;
      meas_valid       <= 1'b0;
      freq_change      <= 1'b0;
      gate_event       <= 1'b0;
      if (!enable) begin
        // Results hold their last values; dropping gate_closed here raises no gate_event.
        state_q     <= StIdle;
        phase_q     <= '0;
        win_cnt_q   <= '0;
        edge_cnt_q  <= '0;
        idle_cnt_q  <= '0;
        gate_closed <= 1'b0;
        hist_q      <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StArm;
            phase_q <= CNT_W'(1);
          end
          StArm: begin
            if (mon_rise) begin
              // The arming edge starts the first window but is not counted in it.
              first_edge_dly   <= phase_q;
              first_edge_valid <= 1'b1;
              state_q          <= StMeasure;
              win_cnt_q        <= '0;
              edge_cnt_q       <= '0;
              idle_cnt_q       <= '0;
            end else if (phase_q != CntMax) begin
              phase_q <= phase_q + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          StMeasure: begin
            if (edge_sat || high_sat) begin
              overflow <= 1'b1;
            end
            if (gate_to) begin
              // Gate timeout wins over a coincident window terminal; partial window dropped.
              state_q     <= StGated;
              gate_closed <= 1'b1;
              gate_event  <= 1'b1;
              win_cnt_q   <= '0;
              edge_cnt_q  <= '0;
              idle_cnt_q  <= '0;
            end else begin
              idle_cnt_q <= mon_rise ? '0 : idle_cnt_q + 1'b1;
              if (win_done) begin
                meas_count  <= edge_nxt;
                meas_valid  <= 1'b1;
                freq_change <= hist_q && (diff > TolW);
                prev_q      <= edge_nxt;
                hist_q      <= 1'b1;
                win_cnt_q   <= '0;
                edge_cnt_q  <= '0;
              end else begin
                win_cnt_q  <= win_cnt_q + 1'b1;
                edge_cnt_q <= edge_nxt;
              end
            end
          end
          StGated: begin
            if (mon_rise) begin
              // Reopening edge is not counted; the next window has no history to compare.
              state_q     <= StMeasure;
              gate_closed <= 1'b0;
              gate_event  <= 1'b1;
              hist_q      <= 1'b0;
              win_cnt_q   <= '0;
              edge_cnt_q  <= '0;
              idle_cnt_q  <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: CLOCK 500 MHz, mon_clk from a table of periods/duties.
// Expected window counts come from 2048 ns / period; freq_change from period history.
`timescale 1ns/1ps
module tb_clock_monitor;

  localparam int unsigned WIN   = 1024;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned GTO   = 64;
  localparam int unsigned TOLV  = 2;
  localparam int unsigned SS    = 2;
  localparam int          NW    = 12;
  localparam int          GATE_W = 6;

  logic             CLOCK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             enable = 1'b0;
  logic             mon_clk = 1'b0;
  logic [CNT_W-1:0] first_edge_dly;
  logic             first_edge_valid;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             freq_change;
  logic             gate_closed;
  logic             gate_event;
  logic             overflow;
`ifdef CLOCK_MONITOR_DUTY_EN
  logic [CNT_W-1:0] high_count;
`endif

  clock_monitor #(
    .WINDOW_CYCLES(WIN),
    .CNT_W        (CNT_W),
    .GATE_TIMEOUT (GTO),
    .TOL          (TOLV),
    .SYNC_STAGES  (SS)
  ) dut (
    .CLOCK           (CLOCK),
    .RESET_N         (RESET_N),
    .enable          (enable),
    .mon_clk         (mon_clk),
    .first_edge_dly  (first_edge_dly),
    .first_edge_valid(first_edge_valid),
    .meas_count      (meas_count),
    .meas_valid      (meas_valid),
    .freq_change     (freq_change),
    .gate_closed     (gate_closed),
    .gate_event      (gate_event),
`ifdef CLOCK_MONITOR_DUTY_EN
    .high_count      (high_count),
`endif
    .overflow        (overflow)
  );

  always #1 CLOCK = ~CLOCK;

  // mon_clk generator: edges sit on x.5 ns, never on a CLOCK edge.
  int      per_tab [8] = '{8, 8, 10, 12, 16, 20, 6, 16};
  int      hi_tab  [8] = '{4, 2, 5, 6, 8, 10, 3, 4};
  bit      mon_run = 1'b0;
  int      mon_high = 4;
  int      mon_low = 4;
  realtime last_rise = 0.0;

  initial begin
    #0.5;
    forever begin
      if (mon_run) begin
        mon_clk = 1'b1;
        last_rise = $realtime;
        #(mon_high);
        mon_clk = 1'b0;
        #(mon_low);
      end else begin
        #1;
      end
    end
  end

  typedef struct {
    int lo;
    int hi;
    int fc;   // 0/1 required, 2 = either
    int hlo;  // < 0: high_count not checked
    int hhi;
  } win_exp_t;

  win_exp_t win_q[$];
  int       fe_q[$];
  int       gate_q[$];
  int       n_checks = 0;
  int       n_pass = 0;

  // Reference-model state: history validity and the period dominating the previous window.
  bit       m_hist = 1'b0;
  int       m_prev_dom = 0;
  int       m_last_lo = 0;
  int       m_last_hi = 0;

  task automatic check(input bit ok, input string name, input int act, input int lo,
                       input int hi);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
  endtask

  task automatic set_gen(input int idx);
    mon_high = hi_tab[idx];
    mon_low  = per_tab[idx] - hi_tab[idx];
  endtask

  // Expectation for one window that starts with table entry ps and ends with pe.
  task automatic push_window(input int ps, input int pe);
    win_exp_t e;
    int p0, p1, lo0, hi0, lo1, hi1, hn;
    p0  = per_tab[ps];
    p1  = per_tab[pe];
    lo0 = (2 * WIN) / p0 - 1;
    hi0 = (2 * WIN + p0 - 1) / p0 + 1;
    lo1 = (2 * WIN) / p1 - 1;
    hi1 = (2 * WIN + p1 - 1) / p1 + 1;
    if (ps == pe) begin
      e.lo  = lo1;
      e.hi  = hi1;
      hn    = (WIN * hi_tab[pe]) / p1;
      e.hlo = hn - 4;
      e.hhi = hn + 4;
      e.fc  = (m_hist && (p1 != m_prev_dom)) ? 1 : 0;
    end else begin
      e.lo  = ((lo0 < lo1) ? lo0 : lo1) - 2;
      e.hi  = ((hi0 > hi1) ? hi0 : hi1) + 2;
      e.hlo = -1;
      e.hhi = -1;
      e.fc  = !m_hist ? 0 : ((p0 == p1) ? 0 : 2);
    end
    m_last_lo  = e.lo;
    m_last_hi  = e.hi;
    m_hist     = 1'b1;
    m_prev_dom = p0;
    win_q.push_back(e);
  endtask

  task automatic wait_mv(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLOCK);
      n++;
    end while (!meas_valid && n < budget);
    check(meas_valid == 1'b1, "meas_valid_timeout", n, 1, budget);
  endtask

  // Enable just after a CLOCK edge, then start mon_clk d ns later (d even).
  task automatic start_phase();
    int d;
    d = 2 * $urandom_range(5, 40);
    @(posedge CLOCK);
    #0.2;
    enable = 1'b1;
    fe_q.push_back(d / 2 + SS + 1);
    #(d);
    mon_run = 1'b1;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a result.
  win_exp_t me;
  int       fe_nom;
  int       g_exp;
  int       g_cyc;
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (meas_valid) begin
        check(win_q.size() > 0, "meas_valid_expected", win_q.size(), 1, 1);
        if (win_q.size() > 0) begin
          me = win_q.pop_front();
          check(int'(meas_count) >= me.lo && int'(meas_count) <= me.hi, "meas_count",
                int'(meas_count), me.lo, me.hi);
          if (me.fc != 2)
            check(int'(freq_change) == me.fc, "freq_change", int'(freq_change), me.fc, me.fc);
`ifdef CLOCK_MONITOR_DUTY_EN
          if (me.hlo >= 0)
            check(int'(high_count) >= me.hlo && int'(high_count) <= me.hhi, "high_count",
                  int'(high_count), me.hlo, me.hhi);
`endif
        end
      end
      if (freq_change)
        check(meas_valid == 1'b1, "freq_change_with_meas_valid", int'(meas_valid), 1, 1);
      if (first_edge_valid) begin
        check(fe_q.size() > 0, "first_edge_valid_expected", fe_q.size(), 1, 1);
        if (fe_q.size() > 0) begin
          fe_nom = fe_q.pop_front();
          check(int'(first_edge_dly) >= fe_nom - 1 && int'(first_edge_dly) <= fe_nom + 1,
                "first_edge_dly", int'(first_edge_dly), fe_nom - 1, fe_nom + 1);
        end
      end
      if (gate_event) begin
        check(gate_q.size() > 0, "gate_event_expected", gate_q.size(), 1, 1);
        if (gate_q.size() > 0) begin
          g_exp = gate_q.pop_front();
          check(int'(gate_closed) == g_exp, "gate_closed_on_event", int'(gate_closed),
                g_exp, g_exp);
          if (g_exp == 1) begin
            g_cyc = int'(($realtime - last_rise) / 2.0);
            check(g_cyc >= GTO - 2 && g_cyc <= GTO + 6, "gate_close_delay", g_cyc,
                  GTO - 2, GTO + 6);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cur;
    int  nxt;
    bit  just_sw;

    // Reset state, checked while reset is asserted and after release.
    #5;
    check(first_edge_dly == '0 && meas_count == '0, "reset_counts", int'(meas_count), 0, 0);
    check({first_edge_valid, meas_valid, freq_change, gate_closed, gate_event, overflow} == '0,
          "reset_flags", int'(overflow), 0, 0);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLOCK);
    check(gate_closed == 1'b0, "idle_gate_closed", int'(gate_closed), 0, 0);
    check(meas_valid == 1'b0 && first_edge_valid == 1'b0, "idle_pulses", int'(meas_valid), 0, 0);

    // Start phase, then a run of windows with random frequency/duty switches and one gating.
    cur = $urandom_range(0, 7);
    set_gen(cur);
    m_hist = 1'b0;
    start_phase();
    push_window(cur, cur);
    just_sw = 1'b0;
    for (int w = 0; w < NW; w++) begin
      wait_mv((w == 0) ? 1300 : 1100);
      if (w == NW - 1) break;
      if (w == GATE_W) begin
        gate_q.push_back(1);
        gate_q.push_back(0);
        mon_run = 1'b0;
        repeat (100) @(negedge CLOCK);
        check(gate_closed == 1'b1, "gate_closed_while_low", int'(gate_closed), 1, 1);
        mon_run = 1'b1;
        repeat (20) @(negedge CLOCK);
        check(gate_closed == 1'b0, "gate_reopened", int'(gate_closed), 0, 0);
        m_hist = 1'b0;
        push_window(cur, cur);
        just_sw = 1'b0;
      end else if (!just_sw && (w == 2 || $urandom_range(0, 2) == 0)) begin
        do nxt = $urandom_range(0, 7); while (nxt == cur);
        push_window(cur, nxt);
        repeat (1000) @(negedge CLOCK);
        set_gen(nxt);
        cur = nxt;
        just_sw = 1'b1;
      end else begin
        push_window(cur, cur);
        just_sw = 1'b0;
      end
    end

    // Disable mid-window: results hold, no pulses while disabled.
    repeat (300) @(negedge CLOCK);
    enable = 1'b0;
    repeat (5) @(negedge CLOCK);
    check(int'(meas_count) >= m_last_lo && int'(meas_count) <= m_last_hi, "meas_count_held",
          int'(meas_count), m_last_lo, m_last_hi);
    check(gate_closed == 1'b0, "disabled_gate_closed", int'(gate_closed), 0, 0);
    repeat (1100) @(negedge CLOCK);
    check(int'(meas_count) >= m_last_lo && int'(meas_count) <= m_last_hi,
          "meas_count_held_long", int'(meas_count), m_last_lo, m_last_hi);

    // Re-enable: start phase measured again, fresh history.
    mon_run = 1'b0;
    repeat (20) @(negedge CLOCK);
    cur = $urandom_range(0, 7);
    set_gen(cur);
    m_hist = 1'b0;
    start_phase();
    push_window(cur, cur);
    wait_mv(1300);
    push_window(cur, cur);
    wait_mv(1100);

    // Asynchronous reset mid-window clears every output at once.
    repeat (400) @(negedge CLOCK);
    check(overflow == 1'b0, "overflow_clear", int'(overflow), 0, 0);
    #0.4;
    RESET_N = 1'b0;
    #0.2;
    check(first_edge_dly == '0, "async_reset_first_edge_dly", int'(first_edge_dly), 0, 0);
    check(meas_count == '0, "async_reset_meas_count", int'(meas_count), 0, 0);
    check({first_edge_valid, meas_valid, freq_change, gate_closed, gate_event, overflow} == '0,
          "async_reset_flags", int'(gate_closed), 0, 0);
`ifdef CLOCK_MONITOR_DUTY_EN
    check(high_count == '0, "async_reset_high_count", int'(high_count), 0, 0);
`endif
    repeat (3) @(negedge CLOCK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
